// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the ALU/comparator datapath: debounced key steps through
// LOAD_A -> LOAD_B -> SHOW, producing one registered signed result with compare flags.
module alu_operand_sequencer #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op_sel,
    input  logic             key_n,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             overflow,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [1:0]       state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_e;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             press_q, press_d;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, alu_r, sum, diff;
    logic             valid_q, ovf_q, lt_q, eq_q, gt_q;
    logic             ovf_r, lt_r, eq_r;

    // Debounced level only follows the synchronised key after CNT_MAX+1 stable mismatched cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) db_d = sync2_q;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end

    assign press_d = db_q & ~db_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            LOAD_A: if (press_q) begin a_d = sw; state_d = LOAD_B; end
            LOAD_B: if (press_q) begin b_d = sw; op_d = op_sel; state_d = SHOW; end
            SHOW:   if (press_q) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    // ALU sees the B/op being captured this cycle, so the result lands with the SHOW entry.
    assign sum  = a_q + b_d;
    assign diff = a_q - b_d;

    always_comb begin
        alu_r = sum;
        ovf_r = 1'b0;
        case (op_d)
            2'b00: begin
                alu_r = sum;
                ovf_r = (a_q[WIDTH-1] == b_d[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b01: begin
                alu_r = diff;
                ovf_r = (a_q[WIDTH-1] != b_d[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b10:   alu_r = a_q & b_d;
            default: alu_r = a_q | b_d;
        endcase
    end

    assign lt_r = $signed(a_q) < $signed(b_d);
    assign eq_r = a_q == b_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            db_q     <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            if (state_d == SHOW) begin
                if (state_q != SHOW) begin
                    result_q <= alu_r;
                    valid_q  <= 1'b1;
                    ovf_q    <= ovf_r;
                    lt_q     <= lt_r;
                    eq_q     <= eq_r;
                    gt_q     <= ~lt_r & ~eq_r;
                end
            end else begin
                result_q <= sw;
                valid_q  <= 1'b0;
                ovf_q    <= 1'b0;
                lt_q     <= 1'b0;
                eq_q     <= 1'b0;
                gt_q     <= 1'b0;
            end
        end
    end

    assign result   = result_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign lt       = lt_q;
    assign eq       = eq_q;
    assign gt       = gt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomised bench for alu_operand_sequencer against an integer-arithmetic reference model.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] sw;
    logic [1:0] op_sel;
    logic       key_n;
    logic [5:0] result;
    logic       valid, overflow, lt, eq, gt;
    logic [1:0] state;

    alu_operand_sequencer #(.WIDTH(6), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .sw(sw), .op_sel(op_sel), .key_n(key_n),
        .result(result), .valid(valid), .overflow(overflow),
        .lt(lt), .eq(eq), .gt(gt), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_trans = 0;
    logic [1:0] prev_state = 2'b00;

    // Reference model: phase plus signed operands as plain integers
    int m_st = 0, m_a = 0, m_b = 0, m_op = 0;
    int e_res = 0, e_ovf = 0, e_lt = 0, e_eq = 0, e_gt = 0;

    always @(negedge clk) begin
        if (state !== prev_state) n_trans++;
        prev_state = state;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [5:0] v);
        return v[5] ? int'(v) - 64 : int'(v);
    endfunction

    task automatic model_press(input logic [5:0] s, input logic [1:0] o);
        logic [5:0] ua, ub;
        int r;
        case (m_st)
            0: begin m_a = sx(s); m_st = 1; end
            1: begin
                m_b  = sx(s);
                m_op = int'(o);
                m_st = 2;
                ua = 6'(m_a);
                ub = 6'(m_b);
                case (m_op)
                    0:       r = m_a + m_b;
                    1:       r = m_a - m_b;
                    2:       r = sx(ua & ub);
                    default: r = sx(ua | ub);
                endcase
                e_ovf = (m_op < 2 && (r > 31 || r < -32)) ? 1 : 0;
                e_res = r & 63;
                e_lt  = (m_a < m_b)  ? 1 : 0;
                e_eq  = (m_a == m_b) ? 1 : 0;
                e_gt  = (m_a > m_b)  ? 1 : 0;
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_st));
        if (m_st == 2) begin
            chk({tag, ".result"}, 32'(result), 32'(e_res));
            chk({tag, ".valid"},  32'(valid), 32'd1);
            chk({tag, ".ovf"},    32'(overflow), 32'(e_ovf));
            chk({tag, ".cmp"},    {29'd0, lt, eq, gt}, 32'({e_lt[0], e_eq[0], e_gt[0]}));
        end else begin
            chk({tag, ".result"}, 32'(result), 32'(sw));
            chk({tag, ".flags"},  {27'd0, valid, overflow, lt, eq, gt}, 32'd0);
        end
    endtask

    // Press with sw/op_sel stable; check the cycle of the transition, then after release.
    task automatic press(input string tag, input logic [5:0] s, input logic [1:0] o, input int hold);
        logic [1:0] st0;
        int k;
        sw = s;
        op_sel = o;
        @(negedge clk);
        st0 = state;
        model_press(s, o);
        key_n = 1'b0;
        k = 0;
        while (state == st0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_outs({tag, ".edge"});
        sw = 6'($urandom);
        op_sel = 2'($urandom);
        repeat (hold) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        check_outs({tag, ".held"});
    endtask

    initial begin
        int t0;
        reset_n = 1'b0;
        key_n   = 1'b1;
        sw      = 6'd5;
        op_sel  = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.state",  32'(state), 32'd0);
        chk("rst.flags",  {27'd0, valid, overflow, lt, eq, gt}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_outs("echo");

        press("d1a", 6'd7, 2'b00, 8);
        press("d1b", 6'h3D, 2'b00, 8);
        press("d1c", 6'd0, 2'b00, 8);
        press("d2a", 6'h20, 2'b00, 8);
        press("d2b", 6'd1, 2'b01, 8);
        press("d2c", 6'd0, 2'b00, 8);
        press("d3a", 6'd31, 2'b00, 8);
        press("d3b", 6'd1, 2'b00, 8);
        press("d3c", 6'd0, 2'b00, 8);
        press("d4a", 6'd12, 2'b00, 8);
        press("d4b", 6'd10, 2'b10, 8);
        press("d4c", 6'd0, 2'b00, 8);
        press("d5a", 6'h3F, 2'b00, 8);
        press("d5b", 6'h3F, 2'b11, 8);
        press("d5c", 6'd0, 2'b00, 8);

        for (int i = 0; i < 20; i++) begin
            press("rnd_a", 6'($urandom), 2'($urandom), $urandom_range(4, 15));
            press("rnd_b", 6'($urandom), 2'($urandom), $urandom_range(4, 15));
            press("rnd_c", 6'($urandom), 2'($urandom), $urandom_range(4, 15));
        end

        // Short lows must never be accepted; a long hold is exactly one press.
        sw = 6'd21;
        op_sel = 2'b00;
        @(negedge clk);
        t0 = n_trans;
        for (int g = 0; g < 8; g++) begin
            key_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            key_n = 1'b1;
            repeat ($urandom_range(2, 4)) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("glitch.trans", 32'(n_trans - t0), 32'd0);
        check_outs("glitch");
        model_press(sw, op_sel);
        key_n = 1'b0;
        repeat (20) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("hold.trans", 32'(n_trans - t0), 32'd1);
        check_outs("hold");

        // Asynchronous reset mid-LOAD_B, then a fresh sequence.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.result", 32'(result), 32'd0);
        chk("arst.state",  32'(state), 32'd0);
        chk("arst.flags",  {27'd0, valid, overflow, lt, eq, gt}, 32'd0);
        m_st = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_outs("arst.echo");
        press("post_a", 6'd9, 2'b00, 8);
        press("post_b", 6'h3A, 2'b01, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
